// File: rtl/escaner_display_pkg.sv
// Shared constants and helpers for the 7-segment scanner.
// Digit count, nibble width, anode-off pattern, one-hot anode helper.
package pkg_display;

   localparam int         NUM_DIG_MAX = 8;
   localparam int         NIB_W       = 4;
   localparam logic [7:0] AN_OFF      = 8'hFF;

   // Active-low one-hot anode pattern for digit idx.
   function automatic logic [NUM_DIG_MAX-1:0] an_onehot(
      input logic [2:0] idx
   );
      return ~(8'b1 << idx);
   endfunction

endpackage

// File: rtl/escaner_display_divisor_refresco.sv
// Refresh prescaler: counts 0..TICKS_DIG-1 and wraps.
// Ports: clk_i, rst_i (sync, high), tick_o (last count), guarda_o.
module divisor_refresco #(
   parameter int TICKS_DIG = 100000,
   parameter int GUARDA    = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   output logic tick_o,
   output logic guarda_o
);

   localparam int W = $clog2(TICKS_DIG);

   logic [W-1:0] cnt_q, cnt_d;

   // guarda_o describes the count being entered on the next edge,
   // so the registered anodes in the parent line up with it.
   always_comb begin
      tick_o   = (cnt_q == W'(TICKS_DIG - 1));
      cnt_d    = tick_o ? '0 : cnt_q + W'(1);
      guarda_o = (int'(cnt_d) < GUARDA);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

endmodule

// File: rtl/escaner_display.sv
// Time-multiplexed 8-digit common-anode 7-segment scanner.
// Ports: Clk, Reset, Valor, Cargar, Habilita, CerosIzq -> Digito, Blanco, AN, Trama.
module escaner_display
   import pkg_display::*;
#(
   parameter int TICKS_DIG = 100000,
   parameter int NUM_DIG   = 8,
   parameter int GUARDA    = 2
) (
   input  logic                   Clk,
   input  logic                   Reset,
   input  logic [31:0]            Valor,
   input  logic                   Cargar,
   input  logic [NUM_DIG_MAX-1:0] Habilita,
   input  logic                   CerosIzq,
   output logic [NIB_W-1:0]       Digito,
   output logic                   Blanco,
   output logic [NUM_DIG_MAX-1:0] AN,
   output logic                   Trama
);

   localparam logic [2:0] ULT = 3'(NUM_DIG - 1);

   logic tick, en_guarda;
   logic frontera, ceros, oscuro;

   logic [2:0]             idx_q, idx_d;
   logic [31:0]            disp_q, disp_d;
   logic [31:0]            shad_q, shad_d;
   logic                   pend_q, pend_d;
   logic                   act_q, act_d;
   logic [NIB_W-1:0]       dig_q, dig_d;
   logic                   blanco_q, blanco_d;
   logic [NUM_DIG_MAX-1:0] an_q, an_d;
   logic                   trama_q, trama_d;

   divisor_refresco #(
      .TICKS_DIG (TICKS_DIG),
      .GUARDA    (GUARDA)
   ) u_div (
      .clk_i    (Clk),
      .rst_i    (Reset),
      .tick_o   (tick),
      .guarda_o (en_guarda)
   );

   always_comb begin
      frontera = tick && (idx_q == ULT);
      idx_d    = idx_q;
      if (tick) idx_d = frontera ? '0 : idx_q + 3'd1;

      disp_d = disp_q;
      shad_d = shad_q;
      pend_d = pend_q;
      // A load coinciding with the boundary bypasses the shadow.
      if (frontera) begin
         pend_d = 1'b0;
         if (Cargar)      disp_d = Valor;
         else if (pend_q) disp_d = shad_q;
      end else if (Cargar) begin
         shad_d = Valor;
         pend_d = 1'b1;
      end

      // Outputs stay dark until the first slot after reset.
      act_d = act_q | tick;

      // Leading zero: this digit and every higher one are zero.
      ceros = 1'b1;
      for (int j = 0; j < NUM_DIG; j++) begin
         if (j >= int'(idx_d) && disp_d[j*4 +: 4] != '0)
            ceros = 1'b0;
      end
      oscuro = !Habilita[idx_d] ||
               (CerosIzq && idx_d != '0 && ceros);

      dig_d    = disp_d[{idx_d, 2'b00} +: 4];
      blanco_d = oscuro;
      an_d     = (en_guarda || oscuro) ? AN_OFF : an_onehot(idx_d);
      trama_d  = frontera;
      if (!act_d) begin
         dig_d    = '0;
         blanco_d = 1'b1;
         an_d     = AN_OFF;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         idx_q    <= ULT;
         disp_q   <= '0;
         shad_q   <= '0;
         pend_q   <= 1'b0;
         act_q    <= 1'b0;
         dig_q    <= '0;
         blanco_q <= 1'b1;
         an_q     <= AN_OFF;
         trama_q  <= 1'b0;
      end else begin
         idx_q    <= idx_d;
         disp_q   <= disp_d;
         shad_q   <= shad_d;
         pend_q   <= pend_d;
         act_q    <= act_d;
         dig_q    <= dig_d;
         blanco_q <= blanco_d;
         an_q     <= an_d;
         trama_q  <= trama_d;
      end
   end

   assign Digito = dig_q;
   assign Blanco = blanco_q;
   assign AN     = an_q;
   assign Trama  = trama_q;

endmodule

// File: tb/tb_escaner_display.sv
// Scoreboard bench for escaner_display (TICKS_DIG=4, GUARDA=1).
// Driver pushes expected outputs per edge; negedge monitor compares.
module tb_escaner_display;

   localparam int T = 4;
   localparam int G = 1;
   localparam int N = 8;

   typedef struct packed {
      logic [7:0] an;
      logic [3:0] dig;
      logic       bl;
      logic       tr;
   } exp_t;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic [31:0] Valor = '0;
   logic        Cargar = 1'b0;
   logic [7:0]  Habilita = 8'hFF;
   logic        CerosIzq = 1'b0;
   logic [3:0]  Digito;
   logic        Blanco;
   logic [7:0]  AN;
   logic        Trama;

   escaner_display #(
      .TICKS_DIG (T),
      .NUM_DIG   (N),
      .GUARDA    (G)
   ) dut (
      .Clk      (Clk),
      .Reset    (Reset),
      .Valor    (Valor),
      .Cargar   (Cargar),
      .Habilita (Habilita),
      .CerosIzq (CerosIzq),
      .Digito   (Digito),
      .Blanco   (Blanco),
      .AN       (AN),
      .Trama    (Trama)
   );

   always #5 Clk = ~Clk;

   int checks = 0;
   int fails  = 0;
   int cyc    = 0;
   exp_t q[$];

   // Reference state: edges since reset, displayed/pending values.
   int          n = 0;
   logic [31:0] m_disp = '0;
   logic [31:0] m_shad = '0;
   bit          m_pend = 0;

   function automatic int cur_dig(input int e);
      return (e / T >= 1) ? ((e / T - 1) % N) : -1;
   endfunction

   function automatic bit is_bnd(input int e);
      return (e % T == 0) && (cur_dig(e) == 0);
   endfunction

   task automatic model_edge();
      exp_t e;
      int   d;
      bit   dark;
      if (Reset) begin
         n = 0; m_disp = '0; m_shad = '0; m_pend = 0;
      end else begin
         n++;
         if (is_bnd(n)) begin
            if (Cargar)      m_disp = Valor;
            else if (m_pend) m_disp = m_shad;
            m_pend = 0;
         end else if (Cargar) begin
            m_shad = Valor;
            m_pend = 1;
         end
      end
      d = cur_dig(n);
      if (d < 0) begin
         e = '{an: 8'hFF, dig: 4'h0, bl: 1'b1, tr: 1'b0};
      end else begin
         dark = !Habilita[d] ||
                (CerosIzq && d != 0 && (m_disp >> (4 * d)) == 0);
         e.dig = 4'((m_disp >> (4 * d)) & 32'hF);
         e.bl  = dark;
         e.an  = ((n % T) < G || dark) ? 8'hFF : ~(8'h01 << d);
         e.tr  = is_bnd(n);
      end
      q.push_back(e);
   endtask

   task automatic step(input bit rst, input bit ld, input logic [31:0] v);
      Reset  = rst;
      Cargar = ld;
      Valor  = v;
      @(posedge Clk);
      model_edge();
      #1;
      Reset  = 1'b0;
      Cargar = 1'b0;
   endtask

   task automatic run(input int k);
      repeat (k) step(0, 0, Valor);
   endtask

   always @(negedge Clk) begin
      exp_t e;
      cyc++;
      if (q.size() > 0) begin
         e = q.pop_front();
         checks++;
         if ({AN, Digito, Blanco, Trama} !== e) begin
            fails++;
            $display("FAIL out cyc=%0d AN=%h/%h Digito=%h/%h Blanco=%b/%b Trama=%b/%b (got/exp)",
                     cyc, AN, e.an, Digito, e.dig, Blanco, e.bl, Trama, e.tr);
         end
         checks++;
         if ($countones(~AN) > 1) begin
            fails++;
            $display("FAIL onehot cyc=%0d AN=%h required at most one low bit", cyc, AN);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int lim;
      #1;
      step(1, 0, '0);
      step(1, 0, '0);
      // Load before the first boundary.
      step(0, 1, 32'h1234ABCD);
      run(40);
      // Mid-frame load is deferred to the next frame.
      lim = 0;
      while (cur_dig(n) != 3 && lim < 64) begin run(1); lim++; end
      step(0, 1, 32'h00000005);
      run(40);
      // Leading-zero suppression.
      CerosIzq = 1'b1;
      step(0, 1, 32'h00000050);
      run(70);
      step(0, 1, 32'h00000000);
      run(40);
      CerosIzq = 1'b0;
      // Partial enable mask.
      Habilita = 8'h0F;
      step(0, 1, 32'h87654321);
      run(70);
      Habilita = 8'hFF;
      // Load exactly on the boundary edge.
      lim = 0;
      while (!is_bnd(n + 1) && lim < 64) begin run(1); lim++; end
      step(0, 1, 32'hFFFFFFFF);
      run(40);
      // Pending load lost to a reset during digit 5.
      step(0, 1, 32'h13572468);
      lim = 0;
      while (cur_dig(n) != 5 && lim < 64) begin run(1); lim++; end
      step(1, 0, Valor);
      run(45);
      // Randomized traffic.
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 9) == 0) Habilita = 8'($urandom);
         if ($urandom_range(0, 19) == 0) CerosIzq = 1'($urandom);
         step($urandom_range(0, 199) == 0,
              $urandom_range(0, 9) == 0,
              ($urandom_range(0, 1) == 0) ? 32'($urandom) : 32'($urandom) & 32'h000000FF);
      end
      @(negedge Clk);
      #1;
      checks++;
      if (q.size() != 0) begin
         fails++;
         $display("FAIL drain: %0d entries left, required 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/escaner_display.md
Name: escaner_display

Overview:
- Time-multiplexed scanner for the 8-digit common-anode 7-segment bank.
- Holds a 32-bit value (8 hex nibbles) and walks the digits at a fixed refresh rate.
- Per slot, drives the active-low anode vector AN and presents that digit's nibble on Digito.
- Digito feeds the 4-bit hex-to-segment decoder, which turns the nibble into segments.
- Value updates are double-buffered and applied only at frame boundaries, so no frame ever mixes two values.

Parameters:
TICKS_DIG, 100000, clock cycles per digit slot (100 MHz -> 1 kHz/digit); legal range 4..2^20.
NUM_DIG, 8, digits scanned (1..8); AN bits >= NUM_DIG are held 1.
GUARDA, 2, cycles at the start of each slot with all anodes off (anti-ghosting); must be < TICKS_DIG.

Ports:
Clk  input  1  system clock; all state changes on the rising edge.
Reset  input  1  synchronous, active-high reset.
Valor  input  32  value to display; nibble i (Valor[4i+3:4i]) goes to digit i, digit 0 rightmost.
Cargar  input  1  one-cycle strobe; captures Valor into the shadow register.
Habilita  input  8  per-digit enable mask; 0 blanks that digit.
CerosIzq  input  1  1 = suppress leading zeros.
Digito  output  4  nibble for the decoder in the current slot (registered).
Blanco  output  1  1 = current slot is dark; the decoder output is a don't-care.
AN  output  8  active-low anodes, at most one bit low (registered).
Trama  output  1  one-cycle pulse on the tick that starts a new frame (digit 0).

Behaviour:
Reset values (synchronous; applies mid-scan too):
- Prescaler = 0, idx = NUM_DIG-1.
- Display register = 0, shadow register = 0, pendiente = 0.
- AN = 8'hFF, Digito = 0, Blanco = 1, Trama = 0.
- Any pending load is discarded.

Prescaler and digit index:
- Prescaler counts 0..TICKS_DIG-1 and wraps. tick = (prescaler == TICKS_DIG-1).
- On tick, idx advances by 1 and wraps NUM_DIG-1 -> 0.
- The first tick after reset selects digit 0 and asserts Trama.

Frame boundary (tick with idx wrapping to 0):
- Trama = 1 for exactly that one cycle.
- If pendiente = 1: display register <= shadow, pendiente <= 0.

Loading:
- Cargar = 1 (not on a boundary): shadow <= Valor, pendiente <= 1.
- Multiple Cargar pulses before a boundary: the last one wins.
- Cargar on the same cycle as a boundary: Valor loads directly into the display register and is used for digit 0 of the new frame; pendiente <= 0.

Slot output, registered and updated on the edge where the slot's values change:
- Digito = nibble idx of the display register (or of the bypass value on a boundary). Digito holds across the whole slot.
- Digit is dark when any of the following holds:
  - Habilita[idx] = 0, or
  - CerosIzq = 1, idx != 0, and nibbles idx..NUM_DIG-1 are all zero.
- Digit 0 is never zero-suppressed.
- Blanco = dark for the whole slot.
- AN = all 1 while the prescaler is < GUARDA, and all 1 when the digit is dark. Otherwise AN[idx] = 0 and all other bits = 1.
- Latency: AN goes low GUARDA cycles after the tick edge and stays low for TICKS_DIG-GUARDA cycles.

Input timing:
- Habilita and CerosIzq are sampled every cycle; a mid-slot change takes effect next cycle.

Invariant: popcount(~AN) <= 1 at all times.

Decomposition:
- Shared package (pkg_display): digit count 8, nibble width 4, anode-off constant 8'hFF, and a function that returns the active-low one-hot anode pattern for an index.
- One natural sub-module, divisor_refresco: the prescaler, emitting tick and the in-guard flag.
- Boundary logic, buffering and the blanking decode stay in escaner_display.

Test Plan:
All scenarios use TICKS_DIG=4, GUARDA=1, NUM_DIG=8.
- Reset, Habilita=FF, Valor=32'h1234ABCD loaded before the first boundary -> cycles 0-3: AN=FF, Blanco=1. First tick: Trama=1, Digito=D. Next cycle: AN=FE. Then Digito C,B,A,4,3,2,1 with AN FD,FB,...,7F, each low 3 of 4 cycles.
- Cargar Valor=32'h00000005 mid-frame -> the remaining digits still show the old value. On the next Trama, digit 0 = 5.
- CerosIzq=1, value 32'h00000050 -> digits 0 and 1 light (0, 5); digits 2-7 Blanco=1, AN=FF. Value 0 -> only digit 0 lights, showing 0.
- Habilita=8'h0F -> digits 4-7 keep AN=FF and Blanco=1; digits 0-3 scan normally.
- Cargar on the exact boundary cycle with Valor=32'hFFFFFFFF -> digit 0 of that frame shows F with no one-frame delay, and pendiente stays 0.
- Reset asserted during digit 5 -> next cycle AN=FF and the display register is 0. The pending load is lost: the next frame shows 0 until a new Cargar.
